// File: rtl/m68040_bus_req_if.sv
// Downstream request/write/read channel between the 68040 bus front-end and the
// request-to-Wishbone bridge.
interface m68040_bus_req_if #(
    parameter int unsigned LW = 3
);
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_addr;
    logic [3:0]    req_mask;
    logic [LW-1:0] req_len;
    logic          req_we;
    logic          req_wrap;
    logic          write_valid;
    logic [31:0]   write_data;
    logic          read_valid;
    logic [31:0]   read_data;
    logic          read_ack;

    modport master (
        output req_valid, req_addr, req_mask, req_len, req_we, req_wrap,
        output write_valid, write_data, read_ack,
        input  req_ready, read_valid, read_data
    );

    modport slave (
        input  req_valid, req_addr, req_mask, req_len, req_we, req_wrap,
        input  write_valid, write_data, read_ack,
        output req_ready, read_valid, read_data
    );
endinterface

// File: rtl/m68040_bus_req.sv
// 68040 bus slave front-end: converts each CPU bus cycle into one bridge request
// and returns TA_n once per data beat.
module m68040_bus_req #(
    parameter int unsigned LW = 3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ts_ni,
    input  logic        rw_i,
    input  logic [1:0]  siz_i,
    input  logic [1:0]  tt_i,
    input  logic [31:0] a_i,
    input  logic [31:0] d_i,
    output logic [31:0] d_o,
    output logic        d_oe_o,
    output logic        ta_no,
    m68040_bus_req_if.master bus
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = 4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WR   = 3'd2,
        S_RD   = 3'd3,
        S_SPEC = 3'd4
    } state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [MW-1:0] mask;
        logic [LW-1:0] len;
        logic          we;
        logic          wrap;
    } req_t;

    state_t        r_state, w_state_nxt;
    req_t          r_req, w_req_nxt, w_dec;
    logic          r_req_valid, w_req_valid_nxt;
    logic          r_write_valid, w_write_valid_nxt;
    logic [DW-1:0] r_write_data, w_write_data_nxt;
    logic          r_ta_n, w_ta_n_nxt;
    logic          r_d_oe, w_d_oe_nxt;
    logic [DW-1:0] r_d_o, w_d_o_nxt;
    logic [LW-1:0] r_beats, w_beats_nxt;
    logic          w_read_ack;
    logic          w_tt0_unused;

    // Only the special-cycle bit of TT matters to this slave
    assign w_tt0_unused = tt_i[0];

    // Bus-cycle decode from the CPU address/size lines
    always_comb begin
        w_dec      = '0;
        w_dec.addr = {a_i[AW-1:2], 2'b00};
        w_dec.we   = ~rw_i;
        w_dec.len  = LW'(1);
        case (siz_i)
            2'b00:   w_dec.mask = 4'b1111;
            2'b01:   w_dec.mask = 4'b1000 >> a_i[1:0];
            2'b10:   w_dec.mask = a_i[1] ? 4'b0011 : 4'b1100;
            default: begin
                w_dec.mask = 4'b1111;
                w_dec.len  = LW'(4);
                w_dec.wrap = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= S_IDLE;
            r_req         <= '0;
            r_req_valid   <= 1'b0;
            r_write_valid <= 1'b0;
            r_write_data  <= '0;
            r_ta_n        <= 1'b1;
            r_d_oe        <= 1'b0;
            r_d_o         <= '0;
            r_beats       <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_req         <= w_req_nxt;
            r_req_valid   <= w_req_valid_nxt;
            r_write_valid <= w_write_valid_nxt;
            r_write_data  <= w_write_data_nxt;
            r_ta_n        <= w_ta_n_nxt;
            r_d_oe        <= w_d_oe_nxt;
            r_d_o         <= w_d_o_nxt;
            r_beats       <= w_beats_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_req_nxt         = r_req;
        w_req_valid_nxt   = r_req_valid;
        w_write_valid_nxt = 1'b0;
        w_write_data_nxt  = r_write_data;
        w_ta_n_nxt        = r_ta_n;
        w_d_oe_nxt        = r_d_oe;
        w_d_o_nxt         = r_d_o;
        w_beats_nxt       = r_beats;
        w_read_ack        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!ts_ni) begin
                    w_req_nxt = w_dec;
                    if (tt_i[1]) begin
                        w_state_nxt = S_SPEC;
                        w_ta_n_nxt  = 1'b0;
                        w_d_o_nxt   = '0;
                        w_d_oe_nxt  = rw_i;
                    end else begin
                        w_state_nxt     = S_REQ;
                        w_req_valid_nxt = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (r_req_valid && bus.req_ready) begin
                    w_req_valid_nxt = 1'b0;
                    w_beats_nxt     = r_req.len;
                    if (r_req.we) begin
                        w_state_nxt = S_WR;
                    end else begin
                        w_state_nxt = S_RD;
                        w_d_oe_nxt  = 1'b1;
                    end
                end
            end
            // Each write beat: assert TA, then capture D while TA is low
            S_WR: begin
                if (r_ta_n) begin
                    w_ta_n_nxt = 1'b0;
                end else begin
                    w_write_valid_nxt = 1'b1;
                    w_write_data_nxt  = d_i;
                    w_ta_n_nxt        = 1'b1;
                    w_beats_nxt       = r_beats - LW'(1);
                    if (r_beats == LW'(1)) w_state_nxt = S_IDLE;
                end
            end
            // Each read beat: pop one word when available, then release TA
            S_RD: begin
                if (r_ta_n) begin
                    if (bus.read_valid) begin
                        w_read_ack = 1'b1;
                        w_d_o_nxt  = bus.read_data;
                        w_ta_n_nxt = 1'b0;
                    end
                end else begin
                    w_ta_n_nxt  = 1'b1;
                    w_beats_nxt = r_beats - LW'(1);
                    if (r_beats == LW'(1)) begin
                        w_d_oe_nxt  = 1'b0;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_SPEC: begin
                w_ta_n_nxt  = 1'b1;
                w_d_oe_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt       = S_IDLE;
                w_req_nxt         = '0;
                w_req_valid_nxt   = 1'b0;
                w_write_data_nxt  = '0;
                w_ta_n_nxt        = 1'b1;
                w_d_oe_nxt        = 1'b0;
                w_d_o_nxt         = '0;
                w_beats_nxt       = '0;
            end
        endcase
    end

    assign d_o             = r_d_o;
    assign d_oe_o          = r_d_oe;
    assign ta_no           = r_ta_n;
    assign bus.req_valid   = r_req_valid;
    assign bus.req_addr    = r_req.addr;
    assign bus.req_mask    = r_req.mask;
    assign bus.req_len     = r_req.len;
    assign bus.req_we      = r_req.we;
    assign bus.req_wrap    = r_req.wrap;
    assign bus.write_valid = r_write_valid;
    assign bus.write_data  = r_write_data;
    assign bus.read_ack    = w_read_ack;

endmodule

// File: tb/tb_m68040_bus_req.sv
// Directed bench for m68040_bus_req: CPU-side driver, small bridge FIFO model and
// a negedge monitor that records every TA, read_ack, write push and request.
module tb_m68040_bus_req;
    localparam int unsigned LW = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ts_n, rw;
    logic [1:0]  siz, tt;
    logic [31:0] a, cpu_d, dout;
    logic        doe, ta_n;
    logic        ready_r;

    always #5 clk = ~clk;

    m68040_bus_req_if #(.LW(LW)) bif ();

    m68040_bus_req #(.LW(LW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .ts_ni(ts_n), .rw_i(rw), .siz_i(siz), .tt_i(tt),
        .a_i(a), .d_i(cpu_d), .d_o(dout), .d_oe_o(doe), .ta_no(ta_n), .bus(bif)
    );

    // Bridge read FIFO model
    logic [31:0] rq_mem [16];
    int          rq_wr = 0;
    int          rq_rd = 0;
    assign bif.req_ready  = ready_r;
    assign bif.read_valid = (rq_wr != rq_rd);
    assign bif.read_data  = rq_mem[4'(rq_rd)];
    always @(posedge clk) if (bif.read_ack === 1'b1) rq_rd <= rq_rd + 1;

    // CPU write data: beat k of the current cycle presents wd_arr[k]
    logic [31:0] wd_arr [4];
    int          beat_idx = 0;
    int          wbase = 0;
    always @(posedge clk) if (ta_n === 1'b0) beat_idx <= beat_idx + 1;
    assign cpu_d = wd_arr[2'(beat_idx - wbase)];

    // Monitor
    int          ta_cnt = 0, ack_cnt = 0, wv_cnt = 0, req_seen = 0;
    int          proto_err = 0, ta_double = 0, stab_err = 0;
    logic [31:0] ta_dout [64];
    logic        ta_oe   [64];
    logic [31:0] ack_data[64];
    logic [31:0] wv_data [64];
    logic [31:0] cap_addr;
    logic [3:0]  cap_mask;
    logic [LW-1:0] cap_len;
    logic        cap_we, cap_wrap;
    logic        prev_rv = 1'b0, prev_ta_low = 1'b0, prev_ack = 1'b0;

    always @(negedge clk) begin
        if (ta_n === 1'b0) begin
            ta_dout[6'(ta_cnt)] <= dout;
            ta_oe[6'(ta_cnt)]   <= doe;
            ta_cnt              <= ta_cnt + 1;
            if (prev_ta_low) ta_double <= ta_double + 1;
        end
        prev_ta_low <= (ta_n === 1'b0);
        if (bif.read_ack === 1'b1) begin
            if (bif.read_valid !== 1'b1 || prev_ack) proto_err <= proto_err + 1;
            ack_data[6'(ack_cnt)] <= bif.read_data;
            ack_cnt               <= ack_cnt + 1;
        end
        prev_ack <= (bif.read_ack === 1'b1);
        if (bif.write_valid === 1'b1) begin
            wv_data[6'(wv_cnt)] <= bif.write_data;
            wv_cnt              <= wv_cnt + 1;
        end
        if (bif.req_valid === 1'b1) begin
            if (!prev_rv) begin
                req_seen <= req_seen + 1;
                cap_addr <= bif.req_addr;
                cap_mask <= bif.req_mask;
                cap_len  <= bif.req_len;
                cap_we   <= bif.req_we;
                cap_wrap <= bif.req_wrap;
            end else if ({bif.req_addr, bif.req_mask, bif.req_len, bif.req_we, bif.req_wrap} !==
                         {cap_addr, cap_mask, cap_len, cap_we, cap_wrap}) begin
                stab_err <= stab_err + 1;
            end
        end
        prev_rv <= (bif.req_valid === 1'b1);
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_rd(input logic [31:0] v);
        rq_mem[4'(rq_wr)] = v;
        rq_wr++;
    endtask

    task automatic start_txn(input logic r, input logic [1:0] s, input logic [1:0] t,
                             input logic [31:0] addr);
        @(posedge clk); #1;
        ts_n = 1'b0; rw = r; siz = s; tt = t; a = addr;
        wbase = beat_idx;
        @(posedge clk); #1;
        ts_n = 1'b1;
    endtask

    task automatic wait_ta(input int target, input string name);
        int b = 0;
        while (ta_cnt < target && b < 200) begin
            @(posedge clk); #1;
            b++;
        end
        chk({name, " TA count"}, 32'(ta_cnt), 32'(target));
    endtask

    task automatic chk_reset_outs(input string name);
        chk({name, " ta_no"},       32'(ta_n),            32'd1);
        chk({name, " req_valid"},   32'(bif.req_valid),   32'd0);
        chk({name, " write_valid"}, 32'(bif.write_valid), 32'd0);
        chk({name, " read_ack"},    32'(bif.read_ack),    32'd0);
        chk({name, " d_oe"},        32'(doe),             32'd0);
        chk({name, " d_o"},         dout,                 32'd0);
    endtask

    typedef struct {
        logic        rw;
        logic [1:0]  siz;
        logic [31:0] a;
        logic [31:0] data;
        logic [31:0] exp_addr;
        logic [3:0]  exp_mask;
        int          exp_len;
        logic        exp_wrap;
    } vec_t;

    vec_t vt [8];

    initial begin
        int ta0, ack0, wv0, rq0;

        vt[0] = '{1'b1, 2'b00, 32'h1000_0004, 32'hDEAD_BEEF, 32'h1000_0004, 4'b1111, 1, 1'b0};
        vt[1] = '{1'b0, 2'b01, 32'h2000_0003, 32'h0000_00A5, 32'h2000_0000, 4'b0001, 1, 1'b0};
        vt[2] = '{1'b1, 2'b01, 32'h2000_0001, 32'h1234_5678, 32'h2000_0000, 4'b0100, 1, 1'b0};
        vt[3] = '{1'b0, 2'b10, 32'h2000_000A, 32'h0000_BEEF, 32'h2000_0008, 4'b0011, 1, 1'b0};
        vt[4] = '{1'b1, 2'b10, 32'h3000_0000, 32'hA5A5_0000, 32'h3000_0000, 4'b1100, 1, 1'b0};
        vt[5] = '{1'b1, 2'b11, 32'h3000_0008, 32'h4000_0000, 32'h3000_0008, 4'b1111, 4, 1'b1};
        vt[6] = '{1'b0, 2'b11, 32'h4000_000C, 32'h7000_0000, 32'h4000_000C, 4'b1111, 4, 1'b1};
        vt[7] = '{1'b0, 2'b00, 32'h8000_0012, 32'h0BAD_CAFE, 32'h8000_0010, 4'b1111, 1, 1'b0};

        ts_n = 1'b1; rw = 1'b1; siz = 2'b00; tt = 2'b00; a = '0; ready_r = 1'b0;
        for (int k = 0; k < 4; k++) wd_arr[k] = '0;

        #2 rst_n = 1'b0;
        #1 chk_reset_outs("reset");
        cyc(3);
        rst_n = 1'b1;
        ready_r = 1'b1;
        cyc(2);

        // Table-driven single and line transfers with an always-ready bridge
        for (int i = 0; i < 8; i++) begin
            ta0 = ta_cnt; ack0 = ack_cnt; wv0 = wv_cnt; rq0 = req_seen;
            for (int k = 0; k < vt[i].exp_len; k++) begin
                wd_arr[k] = vt[i].data + 32'(k);
                if (vt[i].rw) push_rd(vt[i].data + 32'(k));
            end
            start_txn(vt[i].rw, vt[i].siz, 2'b00, vt[i].a);
            wait_ta(ta0 + vt[i].exp_len, $sformatf("v%0d", i));
            cyc(3);
            chk($sformatf("v%0d req count", i), 32'(req_seen - rq0), 32'd1);
            chk($sformatf("v%0d addr", i), cap_addr, vt[i].exp_addr);
            chk($sformatf("v%0d mask", i), 32'(cap_mask), 32'(vt[i].exp_mask));
            chk($sformatf("v%0d len", i), 32'(cap_len), 32'(vt[i].exp_len));
            chk($sformatf("v%0d we", i), 32'(cap_we), 32'(!vt[i].rw));
            chk($sformatf("v%0d wrap", i), 32'(cap_wrap), 32'(vt[i].exp_wrap));
            chk($sformatf("v%0d acks", i), 32'(ack_cnt - ack0), vt[i].rw ? 32'(vt[i].exp_len) : 32'd0);
            chk($sformatf("v%0d pushes", i), 32'(wv_cnt - wv0), vt[i].rw ? 32'd0 : 32'(vt[i].exp_len));
            for (int k = 0; k < vt[i].exp_len; k++) begin
                if (vt[i].rw) begin
                    chk($sformatf("v%0d ack data %0d", i, k), ack_data[6'(ack0 + k)], vt[i].data + 32'(k));
                    chk($sformatf("v%0d d_o at TA %0d", i, k), ta_dout[6'(ta0 + k)], vt[i].data + 32'(k));
                end else begin
                    chk($sformatf("v%0d push data %0d", i, k), wv_data[6'(wv0 + k)], vt[i].data + 32'(k));
                end
            end
            chk($sformatf("v%0d d_oe idle", i), 32'(doe), 32'd0);
        end

        // Line read with the read FIFO empty for 5 cycles before beat 3
        ta0 = ta_cnt; ack0 = ack_cnt;
        push_rd(32'h1111_0000); push_rd(32'h1111_0001);
        start_txn(1'b1, 2'b11, 2'b00, 32'h5000_0008);
        wait_ta(ta0 + 2, "stall first two");
        cyc(5);
        chk("stall no TA", 32'(ta_cnt - ta0), 32'd2);
        chk("stall no ack", 32'(ack_cnt - ack0), 32'd2);
        chk("stall d_oe held", 32'(doe), 32'd1);
        push_rd(32'h1111_0002); push_rd(32'h1111_0003);
        wait_ta(ta0 + 4, "stall all");
        cyc(3);
        for (int k = 0; k < 4; k++)
            chk($sformatf("stall ack order %0d", k), ack_data[6'(ack0 + k)], 32'h1111_0000 + 32'(k));
        chk("stall d_o beat 4", ta_dout[6'(ta0 + 3)], 32'h1111_0003);

        // Line write with req_ready held low for 3 cycles
        ta0 = ta_cnt; wv0 = wv_cnt;
        for (int k = 0; k < 4; k++) wd_arr[k] = 32'h9900_0000 + 32'(k);
        ready_r = 1'b0;
        start_txn(1'b0, 2'b11, 2'b00, 32'h6000_0004);
        cyc(3);
        chk("backpressure req_valid", 32'(bif.req_valid), 32'd1);
        chk("backpressure no push", 32'(wv_cnt - wv0), 32'd0);
        chk("backpressure no TA", 32'(ta_cnt - ta0), 32'd0);
        ready_r = 1'b1;
        wait_ta(ta0 + 4, "line write");
        cyc(3);
        chk("line write pushes", 32'(wv_cnt - wv0), 32'd4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("line write order %0d", k), wv_data[6'(wv0 + k)], 32'h9900_0000 + 32'(k));
        chk("line write addr", cap_addr, 32'h6000_0004);
        chk("req stable", 32'(stab_err), 32'd0);

        // Special/acknowledge cycle: one TA, D driven with zero, no request
        ta0 = ta_cnt; rq0 = req_seen;
        start_txn(1'b1, 2'b00, 2'b11, 32'h7000_0000);
        wait_ta(ta0 + 1, "special");
        cyc(3);
        chk("special single TA", 32'(ta_cnt - ta0), 32'd1);
        chk("special d_o", ta_dout[6'(ta0)], 32'd0);
        chk("special d_oe", 32'(ta_oe[6'(ta0)]), 32'd1);
        chk("special no req", 32'(req_seen - rq0), 32'd0);

        // Reset mid line-read after two beats
        ta0 = ta_cnt;
        push_rd(32'h2222_0000); push_rd(32'h2222_0001);
        start_txn(1'b1, 2'b11, 2'b00, 32'h5000_0000);
        wait_ta(ta0 + 2, "pre-reset");
        cyc(1);
        chk("pre-reset d_oe", 32'(doe), 32'd1);
        rst_n = 1'b0;
        #1 chk_reset_outs("mid-read reset");
        cyc(2);
        chk("no TA in reset", 32'(ta_cnt - ta0), 32'd2);
        rq_wr = rq_rd;
        rst_n = 1'b1;
        cyc(2);

        ta0 = ta_cnt; ack0 = ack_cnt;
        push_rd(32'hCAFE_F00D);
        start_txn(1'b1, 2'b00, 2'b00, 32'h1000_0100);
        wait_ta(ta0 + 1, "post-reset read");
        cyc(3);
        chk("post-reset d_o", ta_dout[6'(ta0)], 32'hCAFE_F00D);
        chk("post-reset ack", 32'(ack_cnt - ack0), 32'd1);
        chk("post-reset len", 32'(cap_len), 32'd1);

        chk("read_ack protocol", 32'(proto_err), 32'd0);
        chk("TA one cycle", 32'(ta_double), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks done", n_chk);
        $fatal(1);
    end
endmodule
